// File: rtl/alu_uart_sequencer_if.sv
// Bus between the frame sequencer and its UART RX/TX and ALU neighbours.
// master: the sequencer (drives operands, opcode, tx request and status pulses).
// slave : the surrounding UART/ALU side (drives rx strobe/data, alu result, tx done).
interface alu_uart_sequencer_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_rx_data;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_operation;
  logic [NB_DATA-1:0] i_alu_result;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               i_tx_done;
  logic               o_busy;
  logic               o_timeout;
  logic               o_overrun;

  modport master (
    input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_operation, o_tx_start, o_tx_data,
           o_busy, o_timeout, o_overrun
  );

  modport slave (
    output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_operation, o_tx_start, o_tx_data,
           o_busy, o_timeout, o_overrun
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Purpose: collect A, B, opcode bytes from UART RX, drive the ALU, send the result byte to UART TX.
// Latency: result latched one edge after the opcode edge; o_tx_start high the following cycle.
// Backpressure: none on RX; bytes arriving while a result is in flight are dropped and flagged (o_overrun).
// Ports: i_clock/i_reset (async, active-low) plus bus (master modport): rx strobe/data in,
//        operands/opcode out to ALU, alu result in, tx start/data out, tx done in,
//        status outputs busy/timeout/overrun.
module alu_uart_sequencer #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  alu_uart_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_B,
    S_GET_OP,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  // Last idle cycle allowed inside a frame before it is discarded.
  localparam logic [NB_TIMEOUT-1:0] TERM = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t              state_q;
  logic [NB_DATA-1:0]  data_a_q;
  logic [NB_DATA-1:0]  data_b_q;
  logic [NB_OP-1:0]    op_q;
  logic [NB_DATA-1:0]  tx_data_q;
  logic                tx_start_q;
  logic                timeout_q;
  logic                overrun_q;
  logic [NB_TIMEOUT-1:0] cnt_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // Pulse outputs default low; each state raises them for one cycle only.
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (bus.i_rx_done) begin
            data_a_q <= bus.i_rx_data;
            state_q  <= S_GET_B;
          end
        end
        S_GET_B: begin
          // A byte on the terminal-count cycle still wins over the timeout.
          if (bus.i_rx_done) begin
            data_b_q <= bus.i_rx_data;
            cnt_q    <= '0;
            state_q  <= S_GET_OP;
          end else if (cnt_q == TERM) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GET_OP: begin
          if (bus.i_rx_done) begin
            op_q    <= bus.i_rx_data[NB_OP-1:0];
            cnt_q   <= '0;
            state_q <= S_EXEC;
          end else if (cnt_q == TERM) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_EXEC: begin
          // Operands/opcode have been registered for a full cycle, so the ALU output is settled.
          tx_data_q  <= bus.i_alu_result;
          tx_start_q <= 1'b1;
          overrun_q  <= bus.i_rx_done;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          overrun_q <= bus.i_rx_done;
          state_q   <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          // A coincident RX byte is still dropped even though we return to IDLE.
          overrun_q <= bus.i_rx_done;
          if (bus.i_tx_done) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_data_a    = data_a_q;
  assign bus.o_data_b    = data_b_q;
  assign bus.o_operation = op_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_start  = tx_start_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_uart_sequencer.sv
module tb_alu_uart_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_uart_sequencer_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_sequencer #(
    .NB_DATA(8), .NB_OP(6), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(10)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small ALU model: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR.
  always_comb begin
    case (bus.o_operation)
      6'h20:   bus.i_alu_result = bus.o_data_a + bus.o_data_b;
      6'h22:   bus.i_alu_result = bus.o_data_a - bus.o_data_b;
      6'h24:   bus.i_alu_result = bus.o_data_a & bus.o_data_b;
      6'h25:   bus.i_alu_result = bus.o_data_a | bus.o_data_b;
      default: bus.i_alu_result = 8'h00;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one byte across exactly one rising edge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_tx_done = 1'b0;
    tick();
    total++; if (bus.o_data_a !== 8'h00) begin bad++; $display("FAIL reset_a got=%h exp=00", bus.o_data_a); end
    total++; if (bus.o_data_b !== 8'h00) begin bad++; $display("FAIL reset_b got=%h exp=00", bus.o_data_b); end
    total++; if (bus.o_operation !== 6'h00) begin bad++; $display("FAIL reset_op got=%h exp=00", bus.o_operation); end
    total++; if (bus.o_tx_data !== 8'h00) begin bad++; $display("FAIL reset_txd got=%h exp=00", bus.o_tx_data); end
    total++; if ({bus.o_tx_start, bus.o_busy, bus.o_timeout, bus.o_overrun} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.o_tx_start, bus.o_busy, bus.o_timeout, bus.o_overrun});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    send_byte(8'h05);
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL add_busy got=%b exp=1", bus.o_busy); end
    send_byte(8'h03);
    send_byte(8'h20);
    // EXEC cycle: operands visible, no start yet.
    total++; if ({bus.o_data_a, bus.o_data_b} !== 16'h0503) begin bad++; $display("FAIL add_operands got=%h exp=0503", {bus.o_data_a, bus.o_data_b}); end
    total++; if (bus.o_operation !== 6'h20) begin bad++; $display("FAIL add_op got=%h exp=20", bus.o_operation); end
    total++; if (bus.o_tx_start !== 1'b0) begin bad++; $display("FAIL add_start_early got=%b exp=0", bus.o_tx_start); end
    tick();
    total++; if (bus.o_tx_start !== 1'b1) begin bad++; $display("FAIL add_start got=%b exp=1", bus.o_tx_start); end
    total++; if (bus.o_tx_data !== 8'h08) begin bad++; $display("FAIL add_txd got=%h exp=08", bus.o_tx_data); end
    tick();
    total++; if (bus.o_tx_start !== 1'b0) begin bad++; $display("FAIL add_start_once got=%b exp=0", bus.o_tx_start); end
    tick();
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL add_wait_busy got=%b exp=1", bus.o_busy); end
    pulse_tx_done();
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL add_idle got=%b exp=0", bus.o_busy); end
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    send_byte(8'h7F);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.o_timeout === 1'b1) pulses++;
      if (i == 9) begin
        total++; if (bus.o_timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", bus.o_timeout); end
      end
    end
    total++; if (bus.o_timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b exp=1", bus.o_timeout); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b exp=0", bus.o_busy); end
    total++; if (bus.o_data_a !== 8'h7F) begin bad++; $display("FAIL to_keep_a got=%h exp=7f", bus.o_data_a); end
    tick();
    tick();
    if (bus.o_timeout === 1'b1) pulses++;
    total++; if (pulses !== 1) begin bad++; $display("FAIL to_once got=%0d exp=1", pulses); end
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    tick();
    total++; if ({bus.o_tx_start, bus.o_tx_data} !== 9'h103) begin bad++; $display("FAIL to_next_frame got=%h exp=103", {bus.o_tx_start, bus.o_tx_data}); end
    tick();
    pulse_tx_done();
  endtask

  task automatic test_overrun();
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h20);
    tick();
    tick();
    // Now in WAIT_TX holding 0x30.
    send_byte(8'hAA);
    total++; if (bus.o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b exp=1", bus.o_overrun); end
    total++; if (bus.o_tx_data !== 8'h30) begin bad++; $display("FAIL ovr_txd got=%h exp=30", bus.o_tx_data); end
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL ovr_state got=%b exp=1", bus.o_busy); end
    tick();
    total++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL ovr_once got=%b exp=0", bus.o_overrun); end
    pulse_tx_done();
    send_byte(8'hFE);
    send_byte(8'h01);
    send_byte(8'h20);
    tick();
    total++; if (bus.o_tx_data !== 8'hFF) begin bad++; $display("FAIL ovr_next_txd got=%h exp=ff", bus.o_tx_data); end
    tick();
    // RX and TX done together in WAIT_TX: drop byte, still return to IDLE.
    bus.i_tx_done = 1'b1;
    send_byte(8'h55);
    bus.i_tx_done = 1'b0;
    total++; if ({bus.o_overrun, bus.o_busy} !== 2'b10) begin bad++; $display("FAIL ovr_coincide got=%b exp=10", {bus.o_overrun, bus.o_busy}); end
    total++; if (bus.o_data_a !== 8'hFE) begin bad++; $display("FAIL ovr_drop_a got=%h exp=fe", bus.o_data_a); end
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h20);
    tick();
    total++; if (bus.o_tx_data !== 8'h05) begin bad++; $display("FAIL ovr_after_txd got=%h exp=05", bus.o_tx_data); end
    tick();
    pulse_tx_done();
  endtask

  task automatic test_opmask();
    send_byte(8'h0F);
    send_byte(8'h3C);
    send_byte(8'hE4);
    total++; if (bus.o_operation !== 6'h24) begin bad++; $display("FAIL mask_op got=%h exp=24", bus.o_operation); end
    tick();
    total++; if (bus.o_tx_data !== 8'h0C) begin bad++; $display("FAIL mask_txd got=%h exp=0c", bus.o_tx_data); end
    tick();
    pulse_tx_done();
  endtask

  task automatic test_async_reset();
    send_byte(8'h44);
    send_byte(8'h55);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.o_data_a, bus.o_data_b, bus.o_tx_data} !== 24'h000000) begin
      bad++; $display("FAIL arst_data got=%h exp=000000", {bus.o_data_a, bus.o_data_b, bus.o_tx_data});
    end
    total++; if ({bus.o_busy, bus.o_operation} !== 7'h00) begin bad++; $display("FAIL arst_state got=%h exp=00", {bus.o_busy, bus.o_operation}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_byte(8'h07);
    send_byte(8'h09);
    send_byte(8'h20);
    tick();
    total++; if ({bus.o_tx_start, bus.o_tx_data} !== 9'h110) begin bad++; $display("FAIL arst_frame got=%h exp=110", {bus.o_tx_start, bus.o_tx_data}); end
    tick();
    pulse_tx_done();
  endtask

  task automatic test_timeout_race();
    send_byte(8'h11);
    for (int i = 0; i < 9; i++) tick();
    // Counter now at the terminal value; a byte this cycle must be accepted.
    send_byte(8'h22);
    total++; if (bus.o_timeout !== 1'b0) begin bad++; $display("FAIL race_timeout got=%b exp=0", bus.o_timeout); end
    total++; if ({bus.o_busy, bus.o_data_b} !== 9'h122) begin bad++; $display("FAIL race_b got=%h exp=122", {bus.o_busy, bus.o_data_b}); end
    send_byte(8'h20);
    tick();
    total++; if (bus.o_tx_data !== 8'h33) begin bad++; $display("FAIL race_txd got=%h exp=33", bus.o_tx_data); end
    tick();
    pulse_tx_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_timeout();
    test_overrun();
    test_opmask();
    test_async_reset();
    test_timeout_race();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
Frame controller between the UART receiver/transmitter and the ALU. It collects a three-byte command frame (operand A, operand B, opcode) from RX, presents the operands and opcode to the ALU, and captures the ALU result. It then hands the result byte to the UART transmitter through a start/done handshake. It adds an inter-byte timeout and flags bytes dropped while a result is in flight.

Parameters:
NB_DATA, 8, UART byte and ALU operand/result width
NB_OP, 6, ALU opcode width (low NB_OP bits of the third byte)
NB_TIMEOUT, 16, width of the inter-byte timeout counter
TIMEOUT_CYCLES, 50000, idle cycles allowed between bytes of one frame

Ports:
i_clock  in  1  system clock, all state on rising edge
i_reset  in  1  asynchronous reset, active-low (asserted when 0)
i_rx_done  in  1  one-cycle strobe, new RX byte on i_rx_data
i_rx_data  in  NB_DATA  received byte
o_data_a  out  NB_DATA  operand A to ALU (signed)
o_data_b  out  NB_DATA  operand B to ALU (signed)
o_operation  out  NB_OP  opcode to ALU
i_alu_result  in  NB_DATA  combinational ALU result
o_tx_start  out  1  one-cycle strobe to the transmitter
o_tx_data  out  NB_DATA  byte to transmit, stable from o_tx_start until i_tx_done
i_tx_done  in  1  one-cycle strobe, transmitter finished
o_busy  out  1  high in every state except IDLE
o_timeout  out  1  one-cycle pulse, partial frame discarded
o_overrun  out  1  one-cycle pulse, RX byte dropped during EXEC/SEND/WAIT_TX

Behaviour:
- Reset (i_reset=0, async): state IDLE. All outputs, the timeout counter and the result register are 0.
- States: IDLE, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- IDLE: on i_rx_done, o_data_a<=i_rx_data and go to GET_B.
- GET_B: on i_rx_done, o_data_b<=i_rx_data and go to GET_OP.
- GET_OP: on i_rx_done, o_operation<=i_rx_data[NB_OP-1:0] and go to EXEC.
- EXEC: lasts exactly one cycle, so the ALU sees stable registered inputs. At the closing edge, o_tx_data<=i_alu_result, o_tx_start<=1 and go to SEND.
- SEND: lasts one cycle. o_tx_start returns to 0 at the closing edge, then go to WAIT_TX.
- WAIT_TX: on i_tx_done, go to IDLE. i_tx_done in any other state is ignored.
- Latency: the result is latched at edge k+1, where edge k captures the opcode. o_tx_start is high during cycle k+1 to k+2.
- Operands and opcode hold their values after the frame completes. They change only when a new frame byte is captured or on reset.
- Timeout:
  - The counter clears on every accepted byte and on entry to IDLE.
  - It increments each cycle in GET_B and GET_OP without i_rx_done.
  - When it reaches TIMEOUT_CYCLES-1 with no byte that cycle, the next state is IDLE and o_timeout pulses for one cycle.
  - o_data_a, o_data_b and o_operation are not cleared on timeout.
  - If i_rx_done coincides with the terminal count, the byte wins: it is accepted and no timeout occurs.
  - The counter saturates and does not wrap.
- Overrun: i_rx_done in EXEC, SEND or WAIT_TX drops the byte, pulses o_overrun and leaves the state unchanged.
  - If i_rx_done and i_tx_done coincide in WAIT_TX, the byte is dropped with o_overrun and the FSM returns to IDLE. The next frame starts with the next byte.
- Reset asserted mid-frame or mid-transmit: immediate return to IDLE with all outputs 0. Any partial frame is lost.
- Widths: no arithmetic on data. Bits of the third byte above NB_OP are ignored.

Test Plan:
- Bytes 0x05, 0x03, 0x20 with the ALU model computing ADD=0x08 -> o_data_a=0x05, o_data_b=0x03, o_operation=0x20. o_tx_start pulses once, 2 cycles after the opcode strobe, with o_tx_data=0x08. After i_tx_done, o_busy=0.
- TIMEOUT_CYCLES=10, send 0x7F then nothing -> o_timeout pulses exactly once, 10 cycles after the strobe; state is IDLE. Then 0x01, 0x02, 0x20 completes normally with o_tx_data=0x03.
- Byte 0xAA strobed during WAIT_TX -> o_overrun pulses, o_tx_data is unchanged. The following frame 0xFE, 0x01, 0x20 gives o_tx_data=0xFF.
- Third byte 0xE4 (NB_OP=6) -> o_operation=0x24.
- i_reset=0 driven asynchronously between bytes 2 and 3 -> all outputs 0 immediately. A full new frame after release is processed correctly.
- i_rx_done on the same cycle the timeout terminal count is reached in GET_B -> byte captured as B, no o_timeout pulse.
